fp_adder_arbiter: RTL and testbench

Shares one combinational fp_adder (1-bit sign, 4-bit exponent, 8-bit normalized fraction) between two requesters.
- Arbitrates requests round-robin.
- Registers the granted operand pair and drives it onto the adder inputs.
- Captures the adder result one cycle later and returns it with a one-cycle done pulse.
- Sits between the user logic (switch/button test front ends, sequencers) and the single fp_adder instance.

---
 rtl/fp_adder_arbiter.sv | 129 ++++++++++++
 tb/tb_fp_adder_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_arbiter.sv
`default_nettype none
// fp_adder_arbiter: shares one combinational fp_adder between two requesters (IDLE -> CALC -> DONE).
// Optional macro FP_ADDER_ARB_FIXED_PRI_EN: fixed priority (requester 0 wins ties) instead of round-robin.
module fp_adder_arbiter #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic              a0_sign,
  input  logic              b0_sign,
  input  logic [EXP_W-1:0]  a0_exp,
  input  logic [EXP_W-1:0]  b0_exp,
  input  logic [FRAC_W-1:0] a0_frac,
  input  logic [FRAC_W-1:0] b0_frac,
  input  logic              a1_sign,
  input  logic              b1_sign,
  input  logic [EXP_W-1:0]  a1_exp,
  input  logic [EXP_W-1:0]  b1_exp,
  input  logic [FRAC_W-1:0] a1_frac,
  input  logic [FRAC_W-1:0] b1_frac,
  output logic              add_sign1,
  output logic              add_sign2,
  output logic [EXP_W-1:0]  add_exp1,
  output logic [EXP_W-1:0]  add_exp2,
  output logic [FRAC_W-1:0] add_frac1,
  output logic [FRAC_W-1:0] add_frac2,
  input  logic              add_sign_out,
  input  logic [EXP_W-1:0]  add_exp_out,
  input  logic [FRAC_W-1:0] add_frac_out,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              res_sign,
  output logic [EXP_W-1:0]  res_exp,
  output logic [FRAC_W-1:0] res_frac,
  output logic              busy,
  output logic [CNT_W-1:0]  op_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   win1;

`ifdef FP_ADDER_ARB_FIXED_PRI_EN
  assign win1 = req[1] & ~req[0];
`else
  logic last_grant;
  // On contention requester 1 wins only if requester 0 owned the adder last.
  assign win1 = req[1] & (~req[0] | ~last_grant);
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req != 2'b00) state_nxt = S_CALC;
      S_CALC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      grant     <= 2'b00;
      done      <= 2'b00;
      add_sign1 <= 1'b0;
      add_sign2 <= 1'b0;
      add_exp1  <= '0;
      add_exp2  <= '0;
      add_frac1 <= '0;
      add_frac2 <= '0;
      res_sign  <= 1'b0;
      res_exp   <= '0;
      res_frac  <= '0;
      op_cnt    <= '0;
`ifndef FP_ADDER_ARB_FIXED_PRI_EN
      last_grant <= 1'b1;
`endif
    end else begin
      done <= 2'b00;
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            owner     <= win1;
            grant     <= win1 ? 2'b10 : 2'b01;
            add_sign1 <= win1 ? a1_sign : a0_sign;
            add_sign2 <= win1 ? b1_sign : b0_sign;
            add_exp1  <= win1 ? a1_exp  : a0_exp;
            add_exp2  <= win1 ? b1_exp  : b0_exp;
            add_frac1 <= win1 ? a1_frac : a0_frac;
            add_frac2 <= win1 ? b1_frac : b0_frac;
          end
        end
        S_CALC: begin
          res_sign <= add_sign_out;
          res_exp  <= add_exp_out;
          res_frac <= add_frac_out;
          done     <= owner ? 2'b10 : 2'b01;
        end
        S_DONE: begin
          op_cnt <= op_cnt + CNT_W'(1);
          grant  <= 2'b00;
`ifndef FP_ADDER_ARB_FIXED_PRI_EN
          last_grant <= owner;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_arbiter.sv
`default_nettype none
// Self-checking bench for fp_adder_arbiter: behavioural fp_adder plus a transaction-level reference model.
module tb_fp_adder_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [12:0] a0, b0, a1, b1;
  logic        add_sign1, add_sign2, add_sign_out;
  logic [3:0]  add_exp1, add_exp2, add_exp_out;
  logic [7:0]  add_frac1, add_frac2, add_frac_out;
  logic [1:0]  grant, done;
  logic        res_sign, busy;
  logic [3:0]  res_exp;
  logic [7:0]  res_frac;
  logic [7:0]  op_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  int          m_left;
  logic        m_owner, m_last;
  logic [12:0] m_ra, m_rb, m_res;
  logic [7:0]  m_cnt;

  always #5 clk = ~clk;

  fp_adder_arbiter #(.EXP_W(4), .FRAC_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a0_sign(a0[12]), .b0_sign(b0[12]), .a0_exp(a0[11:8]), .b0_exp(b0[11:8]),
    .a0_frac(a0[7:0]), .b0_frac(b0[7:0]),
    .a1_sign(a1[12]), .b1_sign(b1[12]), .a1_exp(a1[11:8]), .b1_exp(b1[11:8]),
    .a1_frac(a1[7:0]), .b1_frac(b1[7:0]),
    .add_sign1(add_sign1), .add_sign2(add_sign2), .add_exp1(add_exp1), .add_exp2(add_exp2),
    .add_frac1(add_frac1), .add_frac2(add_frac2),
    .add_sign_out(add_sign_out), .add_exp_out(add_exp_out), .add_frac_out(add_frac_out),
    .grant(grant), .done(done), .res_sign(res_sign), .res_exp(res_exp), .res_frac(res_frac),
    .busy(busy), .op_cnt(op_cnt)
  );

  // Reference float add: align by truncating shift, add/subtract magnitudes, renormalize.
  function automatic logic [12:0] fp_ref(input logic [12:0] x, input logic [12:0] y);
    int sa, sb, ea, eb, ma, mb, t, m, e;
    sa = x[12]; ea = x[11:8]; ma = x[7:0];
    sb = y[12]; eb = y[11:8]; mb = y[7:0];
    if (ea * 256 + ma < eb * 256 + mb) begin
      t = sa; sa = sb; sb = t;
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
    end
    mb = mb >> (ea - eb);
    e = ea;
    m = (sa == sb) ? ma + mb : ma - mb;
    if (m == 0) return 13'h0;
    if (m > 255) begin
      m = m >> 1;
      e = e + 1;
    end
    while (m < 128) begin
      m = m << 1;
      e = e - 1;
    end
    return {1'(sa), 4'(e), 8'(m)};
  endfunction

  assign {add_sign_out, add_exp_out, add_frac_out} =
    fp_ref({add_sign1, add_exp1, add_frac1}, {add_sign2, add_exp2, add_frac2});

  function automatic logic [12:0] rand_op();
    return {1'($urandom_range(1)), 4'($urandom_range(15)), 1'b1, 7'($urandom_range(127))};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_owner = 1'b0; m_last = 1'b1;
    m_ra = '0; m_rb = '0; m_res = '0; m_cnt = '0;
  endtask

  task automatic compare_all();
    logic [1:0] oh;
    oh = m_owner ? 2'b10 : 2'b01;
    check_val("grant", grant, (m_left != 0) ? oh : 2'b00);
    check_val("done", done, (m_left == 1) ? oh : 2'b00);
    check_val("busy", busy, m_left != 0);
    check_val("op_cnt", op_cnt, m_cnt);
    check_val("res", {res_sign, res_exp, res_frac}, m_res);
    check_val("add_a", {add_sign1, add_exp1, add_frac1}, m_ra);
    check_val("add_b", {add_sign2, add_exp2, add_frac2}, m_rb);
    n_done += int'(done[0]) + int'(done[1]);
  endtask

  // One clock: advance the model on the inputs the DUT samples, then compare #1 later.
  task automatic step();
    logic w1;
    @(posedge clk);
    if (reset) model_reset();
    else if (m_left == 0) begin
      if (req != 2'b00) begin
`ifdef FP_ADDER_ARB_FIXED_PRI_EN
        w1 = (req == 2'b10);
`else
        w1 = (req == 2'b10) || (req == 2'b11 && m_last == 1'b0);
`endif
        m_owner = w1;
        m_ra = w1 ? a1 : a0;
        m_rb = w1 ? b1 : b0;
        m_left = 2;
      end
    end else if (m_left == 2) begin
      m_res = fp_ref(m_ra, m_rb);
      m_left = 1;
    end else begin
      m_cnt = m_cnt + 8'd1;
      m_last = m_owner;
      m_left = 0;
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int d0;
    logic [1:0] exp_g;
    reset = 1'b1; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    step();
    step();
    reset = 1'b0;
    step();

    // Directed add: 2.0x82 + 2.0x81 -> 3.0x81
    a0 = {1'b0, 4'd2, 8'h82};
    b0 = {1'b0, 4'd2, 8'h81};
    req = 2'b01;
    step();
    step();
    check_val("tp1_done", done, 2'b01);
    check_val("tp1_res", {res_sign, res_exp, res_frac}, 13'h0381);
    req = 2'b00;
    step();
    check_val("tp1_cnt", op_cnt, 8'd1);
    step();

    // Continuous contention
    do_reset();
    a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
    req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i % 3 == 0) begin
`ifdef FP_ADDER_ARB_FIXED_PRI_EN
        exp_g = 2'b01;
`else
        exp_g = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
        check_val("rr_grant", grant, exp_g);
      end
    end
    check_val("rr_cnt", op_cnt, 8'd4);
    req = 2'b00;
    step();
    step();

    // Operands changed during CALC must be ignored
    a0 = rand_op(); b0 = rand_op();
    req = 2'b01;
    step();
    a0 = rand_op(); b0 = rand_op();
    req = 2'b00;
    step();
    step();

    // Reset while in CALC, then a fresh request from requester 1
    a1 = rand_op(); b1 = rand_op();
    req = 2'b10;
    step();
    do_reset();
    check_val("rst_res", {res_sign, res_exp, res_frac}, 13'h0);
    check_val("rst_cnt", op_cnt, 8'd0);
    for (int i = 0; i < 4; i++) step();
    req = 2'b00;
    step();

    // 256 back-to-back single requests: counter wraps, no pulse lost
    do_reset();
    d0 = n_done;
    req = 2'b01;
    for (int i = 0; i < 768; i++) begin
      a0 = rand_op(); b0 = rand_op();
      step();
    end
    req = 2'b00;
    check_val("wrap_cnt", op_cnt, 8'd0);
    check_val("wrap_dones", n_done - d0, 256);
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req = 2'($urandom_range(3));
      a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
